// File: rtl/ram1024x16_arb.sv
// ram1024x16_arb: two-client round-robin arbiter with independent write/read grants in front of a byte-enabled RAM
module ram1024x16_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [1:0]            Req_Valid,
  input  logic [1:0]            Req_Wr,
  input  logic [2*ADDR_W-1:0]   Req_Addr,
  input  logic [2*DATA_W-1:0]   Req_WD,
  input  logic [3:0]            Req_BE,
  output logic [1:0]            Req_Ready,
  output logic [1:0]            Rsp_Valid,
  output logic [DATA_W-1:0]     Rsp_RD,
  output logic [ADDR_W-1:0]     WA,
  output logic [ADDR_W-1:0]     RA,
  output logic [DATA_W-1:0]     WD,
  output logic [1:0]            WEN,
  output logic                  WClk_En,
  output logic                  RClk_En,
  input  logic [DATA_W-1:0]     RD
);
  logic [ADDR_W-1:0] a0, a1, w_addr;
  logic [1:0] wv, rv, hz;
  logic w_sel, w_acc, r_sel, r_acc, wr_ptr, rd_ptr;
  logic [RD_LAT:0] vld, id;
  assign a0 = Req_Addr[0 +: ADDR_W];
  assign a1 = Req_Addr[ADDR_W +: ADDR_W];
  assign wv = Req_Valid & Req_Wr;
  assign w_sel = (wv == 2'b11) ? wr_ptr : wv[1];
  assign w_acc = |wv;
  assign w_addr = w_sel ? a1 : a0;
  // a read is held off while its address matches the write granted now or the one still on WA
  assign hz[0] = (w_acc && a0 == w_addr) || (WClk_En && a0 == WA);
  assign hz[1] = (w_acc && a1 == w_addr) || (WClk_En && a1 == WA);
  assign rv = Req_Valid & ~Req_Wr & ~hz;
  assign r_sel = (rv == 2'b11) ? rd_ptr : rv[1];
  assign r_acc = |rv;
  assign Req_Ready = Rst ? 2'b00 : ({w_acc & w_sel, w_acc & ~w_sel} | {r_acc & r_sel, r_acc & ~r_sel});
  assign Rsp_Valid = vld[RD_LAT] ? (id[RD_LAT] ? 2'b10 : 2'b01) : 2'b00;
  assign Rsp_RD = vld[RD_LAT] ? RD : '0;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      WA      <= '0;
      RA      <= '0;
      WD      <= '0;
      WEN     <= '0;
      WClk_En <= 1'b0;
      RClk_En <= 1'b0;
      vld     <= '0;
      id      <= '0;
    end else begin
      wr_ptr  <= w_acc ? ~w_sel : wr_ptr;
      rd_ptr  <= r_acc ? ~r_sel : rd_ptr;
      WClk_En <= w_acc;
      RClk_En <= r_acc;
      WEN     <= w_acc ? (w_sel ? Req_BE[3:2] : Req_BE[1:0]) : 2'b00;
      WA      <= w_acc ? w_addr : WA;
      WD      <= w_acc ? (w_sel ? Req_WD[DATA_W +: DATA_W] : Req_WD[0 +: DATA_W]) : WD;
      RA      <= r_acc ? (r_sel ? a1 : a0) : RA;
      vld     <= {vld[RD_LAT-1:0], r_acc};
      id      <= {id[RD_LAT-1:0], r_sel};
    end
  end
endmodule

// File: tb/tb_ram1024x16_arb.sv
// tb_ram1024x16_arb: directed checks of arbitration, RAW hold-off, read latency and reset
module tb_ram1024x16_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid, req_wr, req_ready, rsp_valid, wen;
  logic [19:0] req_addr;
  logic [31:0] req_wd;
  logic [3:0] req_be;
  logic [15:0] rsp_rd, wd, rd, r1;
  logic [9:0] wa, ra;
  logic wclk_en, rclk_en;
  logic [15:0] mem [1024];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  ram1024x16_arb dut (
    .Clk(clk), .Rst(rst), .Req_Valid(req_valid), .Req_Wr(req_wr), .Req_Addr(req_addr),
    .Req_WD(req_wd), .Req_BE(req_be), .Req_Ready(req_ready), .Rsp_Valid(rsp_valid),
    .Rsp_RD(rsp_rd), .WA(wa), .RA(ra), .WD(wd), .WEN(wen), .WClk_En(wclk_en),
    .RClk_En(rclk_en), .RD(rd)
  );
  // two-stage registered read RAM with byte writes landing before the read of the same edge
  always @(posedge clk) begin
    if (wclk_en) begin
      if (wen[0]) mem[wa][7:0] = wd[7:0];
      if (wen[1]) mem[wa][15:8] = wd[15:8];
    end
    if (rclk_en) r1 <= mem[ra];
    rd <= r1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    req_valid = '0; req_wr = '0; req_addr = '0; req_wd = '0; req_be = '0;
  endtask
  task automatic put(input int c, input bit wr, input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
    req_valid[c] = 1'b1; req_wr[c] = wr; req_addr[c*10 +: 10] = a; req_wd[c*16 +: 16] = d; req_be[c*2 +: 2] = be;
  endtask
  task automatic all_zero(input string tag);
    check({tag, "_ready"}, {30'd0, req_ready}, 0);
    check({tag, "_outs"}, {rsp_valid, wen, wclk_en, rclk_en}, 0);
    check({tag, "_addr"}, {wa, ra}, 0);
    check({tag, "_data"}, {wd, rsp_rd}, 0);
  endtask
  // called in the acceptance cycle; response must appear exactly three cycles later
  task automatic expect_rsp(input string tag, input logic [1:0] cl, input logic [15:0] d);
    @(negedge clk); idle();
    check({tag, "_rclk"}, {31'd0, rclk_en}, 1);
    check({tag, "_early1"}, {30'd0, rsp_valid}, 0);
    @(negedge clk);
    check({tag, "_early2"}, {30'd0, rsp_valid}, 0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, cl});
    check({tag, "_rsp_rd"}, {16'd0, rsp_rd}, {16'd0, d});
    @(negedge clk);
    check({tag, "_pulse_end"}, {30'd0, rsp_valid}, 0);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    idle(); req_valid = 2'b11;
    repeat (2) @(negedge clk);
    all_zero("reset");
    // basic write then read after the write has left WA
    rst = 1'b0; idle(); put(0, 1, 10'h005, 16'hBEEF, 2'b11);
    #1 check("w0_ready", {30'd0, req_ready}, 2'b01);
    @(negedge clk); idle();
    check("w0_regs", {wclk_en, wen, wa, wd}, {1'b1, 2'b11, 10'h005, 16'hBEEF});
    @(negedge clk); put(0, 0, 10'h005, 0, 0);
    #1 check("r0_ready", {30'd0, req_ready}, 2'b01);
    check("r0_ra_wait", {31'd0, rclk_en}, 0);
    expect_rsp("r0", 2'b01, 16'hBEEF);
    // byte-enable merge: 0x5555 then 0xAAAA with only the low byte
    @(negedge clk); put(0, 1, 10'h040, 16'h5555, 2'b11);
    #1 check("be_w0_ready", {30'd0, req_ready}, 2'b01);
    @(negedge clk); idle(); put(1, 1, 10'h040, 16'hAAAA, 2'b01);
    #1 check("be_w1_ready", {30'd0, req_ready}, 2'b10);
    @(negedge clk); idle();
    check("be_w1_regs", {wen, wd}, {2'b01, 16'hAAAA});
    @(negedge clk); put(0, 0, 10'h040, 0, 0);
    #1 check("be_r_ready", {30'd0, req_ready}, 2'b01);
    expect_rsp("be", 2'b01, 16'h55AA);
    // write contention alternates starting with client 0
    @(negedge clk); put(0, 1, 10'h100, 16'h1111, 2'b11); put(1, 1, 10'h200, 16'h2222, 2'b11);
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rr_ready%0d", k), {30'd0, req_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      if (k == 3) idle();
      check($sformatf("rr_wa%0d", k), {22'd0, wa}, (k % 2 == 0) ? 10'h100 : 10'h200);
    end
    // RAW: read of the address being written is held off, then returns new data
    @(negedge clk); put(1, 1, 10'h3FF, 16'h1234, 2'b11); put(0, 0, 10'h3FF, 0, 0);
    #1 check("raw_ready", {30'd0, req_ready}, 2'b10);
    @(negedge clk); idle(); put(0, 0, 10'h3FF, 0, 0);
    check("raw_wa", {wclk_en, wa}, {1'b1, 10'h3FF});
    begin
      bit got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
        #1 got = req_ready[0];
        if (!got) @(negedge clk);
      end
      check("raw_accepted", {31'd0, got}, 1);
      if (got) expect_rsp("raw", 2'b01, 16'h1234);
    end
    // simultaneous write and read of different addresses
    @(negedge clk); idle(); put(0, 1, 10'h010, 16'h0F0F, 2'b11); put(1, 0, 10'h020, 0, 0);
    #1 check("wr_rd_ready", {30'd0, req_ready}, 2'b11);
    @(negedge clk); idle();
    check("wr_rd_strobes", {wclk_en, rclk_en, wa, ra}, {1'b1, 1'b1, 10'h010, 10'h020});
    repeat (2) @(negedge clk);
    check("wr_rd_rsp", {rsp_valid, rsp_rd}, {2'b10, 16'h0000});
    // reset with a read in flight
    @(negedge clk); put(0, 0, 10'h005, 0, 0);
    #1 check("rst_r_ready", {30'd0, req_ready}, 2'b01);
    @(negedge clk); idle(); rst = 1'b1; req_valid = 2'b11;
    #1 all_zero("rst_mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_rsp%0d", k), {30'd0, rsp_valid}, 0);
    end
    idle(); rst = 1'b0; put(0, 0, 10'h005, 0, 0); put(1, 0, 10'h040, 0, 0);
    #1 check("rst_rr_c0", {30'd0, req_ready}, 2'b01);
    @(negedge clk); idle();
    check("rst_post_rsp", {30'd0, rsp_valid}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
